priority_intr_ctrl: RTL

Parametrised, APB-programmable priority interrupt controller; successor to the fixed 16-source controller. Collects up to 32 peripheral interrupt lines, each with programmable priority, enable, and level/edge mode, plus a global priority threshold. Presents one winning source at a time to the processor and holds it until the processor acknowledges service. Sits between the peripheral interrupt lines and the CPU interrupt input, configured over the APB slave port.

---
 rtl/priority_intr_ctrl.sv | 279 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/priority_intr_ctrl.sv
// APB-programmable priority interrupt controller: per-source priority/enable/edge mode,
// global threshold, and a present-and-hold handshake toward the processor.
module priority_intr_ctrl #(
    parameter int unsigned NUM_PERIPHS = 16,
    parameter int unsigned PRIO_WIDTH  = $clog2(NUM_PERIPHS),
    parameter int unsigned ADDR_WIDTH  = 6,
    parameter int unsigned DATA_WIDTH  = 32,
    localparam int unsigned ID_WIDTH   = (NUM_PERIPHS > 1) ? $clog2(NUM_PERIPHS) : 1
) (
    input  logic                   pclk_i,
    input  logic                   prst_i,
    input  logic [ADDR_WIDTH-1:0]  paddr_i,
    input  logic                   pwrite_i,
    input  logic [DATA_WIDTH-1:0]  pwdata_i,
    input  logic                   penable_i,
    output logic [DATA_WIDTH-1:0]  prdata_o,
    output logic                   pready_o,
    output logic                   perror_o,
    input  logic [NUM_PERIPHS-1:0] intr_active_i,
    input  logic                   intr_serviced_i,
    output logic                   intr_valid_o,
    output logic [ID_WIDTH-1:0]    intr_to_service_o,
    output logic [PRIO_WIDTH-1:0]  intr_prio_o
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ENABLE    = ADDR_WIDTH'(32'h20);
    localparam logic [ADDR_WIDTH-1:0] ADDR_EDGE_MODE = ADDR_WIDTH'(32'h21);
    localparam logic [ADDR_WIDTH-1:0] ADDR_PENDING   = ADDR_WIDTH'(32'h22);
    localparam logic [ADDR_WIDTH-1:0] ADDR_THRESHOLD = ADDR_WIDTH'(32'h23);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS    = ADDR_WIDTH'(32'h24);

    typedef enum logic {
        APB_IDLE,
        APB_RESP
    } apb_state_e;

    typedef enum logic [1:0] {
        INTR_IDLE,
        INTR_ARB,
        INTR_WAIT
    } intr_state_e;

    // Configuration registers
    logic [PRIO_WIDTH-1:0]  prio_q [NUM_PERIPHS];
    logic [PRIO_WIDTH-1:0]  prio_d [NUM_PERIPHS];
    logic [NUM_PERIPHS-1:0] enable_q, enable_d;
    logic [NUM_PERIPHS-1:0] edge_mode_q, edge_mode_d;
    logic [PRIO_WIDTH-1:0]  thresh_q, thresh_d;

    // Line sampling and edge-pending state
    logic [NUM_PERIPHS-1:0] line_q, line_d;
    logic [NUM_PERIPHS-1:0] line_prev_q, line_prev_d;
    logic [NUM_PERIPHS-1:0] edge_pend_q, edge_pend_d;

    // APB response state
    apb_state_e             apb_state_q, apb_state_d;
    logic                   pready_q, pready_d;
    logic                   perror_q, perror_d;
    logic [DATA_WIDTH-1:0]  prdata_q, prdata_d;

    // Interrupt presentation state
    intr_state_e            intr_state_q, intr_state_d;
    logic                   valid_q, valid_d;
    logic [ID_WIDTH-1:0]    id_q, id_d;
    logic [PRIO_WIDTH-1:0]  iprio_q, iprio_d;

    // Combinational helpers
    logic                   acc_c;
    logic                   hit_prio_c;
    logic                   addr_ok_c;
    logic                   err_c;
    logic                   wr_c;
    logic [31:0]            status_c;
    logic [DATA_WIDTH-1:0]  rdata_c;
    logic [NUM_PERIPHS-1:0] rise_c;
    logic [NUM_PERIPHS-1:0] w1c_c;
    logic [NUM_PERIPHS-1:0] svc_c;
    logic [NUM_PERIPHS-1:0] pending_c;
    logic [NUM_PERIPHS-1:0] elig_c;
    logic                   win_found_c;
    logic [ID_WIDTH-1:0]    win_id_c;
    logic [PRIO_WIDTH-1:0]  win_prio_c;
    logic                   unused_pwdata_c;

    assign unused_pwdata_c = ^pwdata_i;

    // Access decode: an access is accepted only from the idle access state
    always_comb begin
        acc_c      = (apb_state_q == APB_IDLE) && penable_i;
        hit_prio_c = (paddr_i < ADDR_WIDTH'(NUM_PERIPHS));
        addr_ok_c  = hit_prio_c
                  || (paddr_i == ADDR_ENABLE)
                  || (paddr_i == ADDR_EDGE_MODE)
                  || (paddr_i == ADDR_PENDING)
                  || (paddr_i == ADDR_THRESHOLD)
                  || (paddr_i == ADDR_STATUS);
        err_c      = !addr_ok_c || (pwrite_i && (paddr_i == ADDR_STATUS));
        wr_c       = acc_c && pwrite_i && !err_c;
    end

    // Read mux
    always_comb begin
        status_c                     = '0;
        status_c[31]                 = valid_q;
        status_c[8 +: PRIO_WIDTH]    = iprio_q;
        status_c[ID_WIDTH-1:0]       = id_q;
        rdata_c                      = '0;
        if (hit_prio_c) begin
            for (int i = 0; i < int'(NUM_PERIPHS); i++) begin
                if (paddr_i == ADDR_WIDTH'(i)) begin
                    rdata_c = DATA_WIDTH'(prio_q[i]);
                end
            end
        end else begin
            case (paddr_i)
                ADDR_ENABLE:    rdata_c = DATA_WIDTH'(enable_q);
                ADDR_EDGE_MODE: rdata_c = DATA_WIDTH'(edge_mode_q);
                ADDR_PENDING:   rdata_c = DATA_WIDTH'(pending_c);
                ADDR_THRESHOLD: rdata_c = DATA_WIDTH'(thresh_q);
                ADDR_STATUS:    rdata_c = DATA_WIDTH'(status_c);
                default:        rdata_c = '0;
            endcase
        end
    end

    // APB two-cycle handshake
    always_comb begin
        apb_state_d = apb_state_q;
        pready_d    = 1'b0;
        perror_d    = 1'b0;
        prdata_d    = '0;
        case (apb_state_q)
            APB_IDLE: begin
                if (acc_c) begin
                    apb_state_d = APB_RESP;
                    pready_d    = 1'b1;
                    perror_d    = err_c;
                    prdata_d    = (err_c || pwrite_i) ? '0 : rdata_c;
                end
            end
            APB_RESP: apb_state_d = APB_IDLE;
            default:  apb_state_d = APB_IDLE;
        endcase
    end

    // Register writes, committed on the edge that raises pready_o
    always_comb begin
        prio_d      = prio_q;
        enable_d    = enable_q;
        edge_mode_d = edge_mode_q;
        thresh_d    = thresh_q;
        if (wr_c) begin
            for (int i = 0; i < int'(NUM_PERIPHS); i++) begin
                if (paddr_i == ADDR_WIDTH'(i)) begin
                    prio_d[i] = pwdata_i[PRIO_WIDTH-1:0];
                end
            end
            if (paddr_i == ADDR_ENABLE)    enable_d    = pwdata_i[NUM_PERIPHS-1:0];
            if (paddr_i == ADDR_EDGE_MODE) edge_mode_d = pwdata_i[NUM_PERIPHS-1:0];
            if (paddr_i == ADDR_THRESHOLD) thresh_d    = pwdata_i[PRIO_WIDTH-1:0];
        end
    end

    // Pending: level follows the registered line, edge latches rising transitions (set beats clear)
    always_comb begin
        line_d      = intr_active_i;
        line_prev_d = line_q;
        rise_c      = line_q & ~line_prev_q & edge_mode_q;
        w1c_c       = '0;
        if (wr_c && (paddr_i == ADDR_PENDING)) begin
            w1c_c = pwdata_i[NUM_PERIPHS-1:0] & edge_mode_q;
        end
        svc_c = '0;
        if ((intr_state_q == INTR_WAIT) && intr_serviced_i) begin
            svc_c = NUM_PERIPHS'(1) << id_q;
        end
        edge_pend_d = (edge_pend_q & ~(w1c_c | svc_c)) | rise_c;
        pending_c   = (edge_mode_q & edge_pend_q) | (~edge_mode_q & line_q);
    end

    // Arbitration: highest priority wins, strict compare keeps the lowest index on ties
    always_comb begin
        elig_c      = '0;
        win_found_c = 1'b0;
        win_id_c    = '0;
        win_prio_c  = '0;
        for (int i = 0; i < int'(NUM_PERIPHS); i++) begin
            elig_c[i] = pending_c[i] && enable_q[i] && (prio_q[i] >= thresh_q);
        end
        for (int i = 0; i < int'(NUM_PERIPHS); i++) begin
            if (elig_c[i] && (!win_found_c || (prio_q[i] > win_prio_c))) begin
                win_found_c = 1'b1;
                win_id_c    = ID_WIDTH'(i);
                win_prio_c  = prio_q[i];
            end
        end
    end

    // Interrupt FSM: winner is latched in ARB and held untouched through WAIT
    always_comb begin
        intr_state_d = intr_state_q;
        valid_d      = valid_q;
        id_d         = id_q;
        iprio_d      = iprio_q;
        case (intr_state_q)
            INTR_IDLE: begin
                valid_d = 1'b0;
                if (|elig_c) intr_state_d = INTR_ARB;
            end
            INTR_ARB: begin
                if (win_found_c) begin
                    id_d         = win_id_c;
                    iprio_d      = win_prio_c;
                    valid_d      = 1'b1;
                    intr_state_d = INTR_WAIT;
                end else begin
                    intr_state_d = INTR_IDLE;
                end
            end
            INTR_WAIT: begin
                valid_d = 1'b1;
                if (intr_serviced_i) begin
                    valid_d      = 1'b0;
                    intr_state_d = INTR_IDLE;
                end
            end
            default: begin
                valid_d      = 1'b0;
                intr_state_d = INTR_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            for (int i = 0; i < int'(NUM_PERIPHS); i++) begin
                prio_q[i] <= '0;
            end
            enable_q     <= '1;
            edge_mode_q  <= '0;
            thresh_q     <= '0;
            line_q       <= '0;
            line_prev_q  <= '0;
            edge_pend_q  <= '0;
            apb_state_q  <= APB_IDLE;
            pready_q     <= 1'b0;
            perror_q     <= 1'b0;
            prdata_q     <= '0;
            intr_state_q <= INTR_IDLE;
            valid_q      <= 1'b0;
            id_q         <= '0;
            iprio_q      <= '0;
        end else begin
            prio_q       <= prio_d;
            enable_q     <= enable_d;
            edge_mode_q  <= edge_mode_d;
            thresh_q     <= thresh_d;
            line_q       <= line_d;
            line_prev_q  <= line_prev_d;
            edge_pend_q  <= edge_pend_d;
            apb_state_q  <= apb_state_d;
            pready_q     <= pready_d;
            perror_q     <= perror_d;
            prdata_q     <= prdata_d;
            intr_state_q <= intr_state_d;
            valid_q      <= valid_d;
            id_q         <= id_d;
            iprio_q      <= iprio_d;
        end
    end

    assign prdata_o          = prdata_q;
    assign pready_o          = pready_q;
    assign perror_o          = perror_q;
    assign intr_valid_o      = valid_q;
    assign intr_to_service_o = id_q;
    assign intr_prio_o       = iprio_q;

endmodule
